// File: rtl/or8_way_reg_if.sv
// or8_way_reg_if: input vector, enable/clear controls and OR results of the registered OR.
interface or8_way_reg_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in;
  logic             en;
  logic             clr;
  logic             out_comb;
  logic             out;
  logic             seen;
  modport master (output in, en, clr, input out_comb, out, seen);
  modport slave  (input in, en, clr, output out_comb, out, seen);
endinterface

// File: rtl/or8_way_reg.sv
// or8_way_reg: OR-reduction with a combinational result, an enabled registered copy and a sticky flag.
module or8_way_reg (
  input  logic           clk,
  input  logic           reset,
  or8_way_reg_if.slave   bus
);
  logic any;
  logic out_d, out_q;
  logic seen_d, seen_q;
  assign any = |bus.in;
  // A qualified set on the same edge as clr takes priority over the clear.
  always_comb begin
    out_d  = bus.en ? any : out_q;
    seen_d = (bus.en && any) ? 1'b1 : bus.clr ? 1'b0 : seen_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      seen_q <= seen_d;
    end
  end
  assign bus.out_comb = any;
  assign bus.out      = out_q;
  assign bus.seen     = seen_q;
endmodule

// File: tb/tb_or8_way_reg.sv
// tb_or8_way_reg: directed vectors with hand-computed expectations for or8_way_reg.
module tb_or8_way_reg;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  or8_way_reg_if #(.WIDTH(8)) bus ();
  or8_way_reg dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic comb(input logic [7:0] v, input logic exp);
    bus.in = v;
    #1;
    chk($sformatf("comb_%b", v), bus.out_comb, exp);
  endtask
  initial begin
    reset   = 1'b1;
    bus.en  = 1'b0;
    bus.clr = 1'b0;
    bus.in  = 8'h00;
    comb(8'b00000000, 1'b0);
    comb(8'b11111111, 1'b1);
    comb(8'b00010000, 1'b1);
    comb(8'b00000001, 1'b1);
    comb(8'b00100110, 1'b1);
    tick();
    chk("rst_out", bus.out, 1'b0);
    chk("rst_seen", bus.seen, 1'b0);
    chk("rst_comb", bus.out_comb, 1'b1);
    reset  = 1'b0;
    bus.en = 1'b1;
    bus.in = 8'b00000000; tick(); chk("lat0", bus.out, 1'b0);
    chk("lat0_seen", bus.seen, 1'b0);
    bus.in = 8'b11111111; tick(); chk("lat1", bus.out, 1'b1);
    bus.in = 8'b00010000; tick(); chk("lat2", bus.out, 1'b1);
    bus.in = 8'b00000000; tick(); chk("lat3", bus.out, 1'b0);
    chk("lat3_seen", bus.seen, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    bus.en = 1'b1; bus.in = 8'b00000001; tick();
    chk("hold_load", bus.out, 1'b1);
    bus.en = 1'b0; bus.in = 8'b00000000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_out%0d", i), bus.out, 1'b1);
      chk($sformatf("hold_seen%0d", i), bus.seen, 1'b1);
    end
    bus.en = 1'b1; tick();
    chk("hold_reload", bus.out, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("sticky_rst", bus.seen, 1'b0);
    bus.en = 1'b1; bus.in = 8'b00100110; tick();
    chk("sticky_set", bus.seen, 1'b1);
    bus.in = 8'b00000000;
    tick(); chk("sticky_hold0", bus.seen, 1'b1);
    tick(); chk("sticky_hold1", bus.seen, 1'b1);
    bus.clr = 1'b1; tick();
    chk("sticky_clr", bus.seen, 1'b0);
    bus.in = 8'b10000000; tick();
    chk("set_wins", bus.seen, 1'b1);
    chk("set_wins_out", bus.out, 1'b1);
    bus.clr = 1'b0;
    reset = 1'b1; bus.en = 1'b1; bus.in = 8'b11111111; tick();
    chk("rstpri_out", bus.out, 1'b0);
    chk("rstpri_seen", bus.seen, 1'b0);
    reset = 1'b0; tick();
    chk("resume_out", bus.out, 1'b1);
    chk("resume_seen", bus.seen, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
